// File: rtl/km_mask_streamer.sv
// Captures one 1-bit mask frame and replays it in raster order (plus a flush column) to the k-means block.
// Optional KM_STREAMER_TEST_PATTERN_EN adds test_mode_in, which replaces memory data with two fixed 8x8 squares.
module km_mask_streamer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 180,
    parameter int PARK_X = 511,
    parameter int PARK_Y = 255
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [8:0] pixel_x_in,
    input  logic [7:0] pixel_y_in,
    input  logic       mask_in,
    input  logic       pixel_valid_in,
    input  logic       frame_done_in,
    input  logic       km_done_in,
`ifdef KM_STREAMER_TEST_PATTERN_EN
    input  logic       test_mode_in,
`endif
    output logic [8:0] x_out,
    output logic [7:0] y_out,
    output logic       mask_out,
    output logic       new_frame_out,
    output logic       busy_out,
    output logic [7:0] frames_dropped_out
);

    localparam int         DEPTH  = WIDTH * HEIGHT;
    localparam int         AW     = $clog2(DEPTH + 1);
    localparam logic [8:0] X_END  = 9'(WIDTH);
    localparam logic [7:0] Y_END  = 8'(HEIGHT);
    localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);
    localparam logic [8:0] X_PARK = 9'(PARK_X);
    localparam logic [7:0] Y_PARK = 8'(PARK_Y);

    typedef enum logic [1:0] {SYNC, CAPTURE, WAIT_KM, STREAM} state_t;

    state_t          state;
    logic            km_ready;
    logic            drain;
    logic [8:0]      cx;
    logic [7:0]      cy;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   wr_addr;
    logic            wr_en;
    logic            beat_bit;
    logic            mem [DEPTH];

`ifdef KM_STREAMER_TEST_PATTERN_EN
    function automatic logic in_pattern(input logic [8:0] x, input logic [7:0] y);
        return (x >= 9'd40  && x <= 9'd47  && y >= 8'd40  && y <= 8'd47) ||
               (x >= 9'd200 && x <= 9'd207 && y >= 8'd100 && y <= 8'd107);
    endfunction
`endif

    assign wr_addr = AW'(pixel_y_in) * AW'(WIDTH) + AW'(pixel_x_in);
    assign wr_en   = (state == CAPTURE) && pixel_valid_in &&
                     (pixel_x_in < X_END) && (pixel_y_in < Y_END);

    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= mask_in;
    end

    // The flush column (cx == WIDTH) never touches memory; rd_addr only advances on real pixels.
    always_comb begin
        beat_bit = 1'b0;
        if (cx != X_END) beat_bit = mem[rd_addr];
`ifdef KM_STREAMER_TEST_PATTERN_EN
        if (test_mode_in) beat_bit = in_pattern(cx, cy);
`endif
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state              <= SYNC;
            km_ready           <= 1'b1;
            drain              <= 1'b0;
            cx                 <= '0;
            cy                 <= '0;
            rd_addr            <= '0;
            x_out              <= X_PARK;
            y_out              <= Y_PARK;
            mask_out           <= 1'b0;
            new_frame_out      <= 1'b0;
            busy_out           <= 1'b0;
            frames_dropped_out <= '0;
        end else begin
            new_frame_out <= 1'b0;

            // A km_done_in landing on the new_frame_out cycle must not be lost.
            if (km_done_in)         km_ready <= 1'b1;
            else if (new_frame_out) km_ready <= 1'b0;

            if (frame_done_in && (state == WAIT_KM || state == STREAM) &&
                frames_dropped_out != 8'hFF)
                frames_dropped_out <= frames_dropped_out + 8'd1;

            case (state)
                SYNC: begin
                    if (frame_done_in) begin
                        state    <= CAPTURE;
                        busy_out <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (frame_done_in) state <= (km_ready || km_done_in) ? STREAM : WAIT_KM;
                end
                WAIT_KM: begin
                    if (km_ready || km_done_in) state <= STREAM;
                end
                STREAM: begin
                    if (drain) begin
                        state         <= SYNC;
                        busy_out      <= 1'b0;
                        new_frame_out <= 1'b1;
                        x_out         <= X_PARK;
                        y_out         <= Y_PARK;
                        mask_out      <= 1'b0;
                        drain         <= 1'b0;
                        cx            <= '0;
                        cy            <= '0;
                        rd_addr       <= '0;
                    end else begin
                        x_out    <= cx;
                        y_out    <= cy;
                        mask_out <= beat_bit;
                        if (cx == X_END) begin
                            cx <= '0;
                            if (cy == Y_LAST) drain <= 1'b1;
                            else              cy    <= cy + 8'd1;
                        end else begin
                            cx      <= cx + 9'd1;
                            rd_addr <= rd_addr + AW'(1);
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_km_mask_streamer.sv
// Randomized bench for km_mask_streamer: a frame-array model predicts the full raster stream,
// pulse timing, drop counting and reset behaviour.
module tb_km_mask_streamer;

`ifdef KM_STREAMER_TEST_PATTERN_EN
    localparam int W = 320;
    localparam int H = 180;
`else
    localparam int W = 48;
    localparam int H = 12;
`endif
    localparam int N = H * (W + 1);

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [8:0] pixel_x_in;
    logic [7:0] pixel_y_in;
    logic       mask_in;
    logic       pixel_valid_in;
    logic       frame_done_in;
    logic       km_done_in;
`ifdef KM_STREAMER_TEST_PATTERN_EN
    logic       test_mode_in;
`endif
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic       mask_out;
    logic       new_frame_out;
    logic       busy_out;
    logic [7:0] frames_dropped_out;

    always #5 clk_in = ~clk_in;

    km_mask_streamer #(.WIDTH(W), .HEIGHT(H), .PARK_X(511), .PARK_Y(255)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .pixel_x_in         (pixel_x_in),
        .pixel_y_in         (pixel_y_in),
        .mask_in            (mask_in),
        .pixel_valid_in     (pixel_valid_in),
        .frame_done_in      (frame_done_in),
        .km_done_in         (km_done_in),
`ifdef KM_STREAMER_TEST_PATTERN_EN
        .test_mode_in       (test_mode_in),
`endif
        .x_out              (x_out),
        .y_out              (y_out),
        .mask_out           (mask_out),
        .new_frame_out      (new_frame_out),
        .busy_out           (busy_out),
        .frames_dropped_out (frames_dropped_out)
    );

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Any non-parked x_out is a streamed beat.
    int bx[$], by[$], bm[$], bc[$];
    int nf_cnt = 0;
    int nf_cyc = -1;
    always @(negedge clk_in) begin
        if (x_out != 9'd511) begin
            bx.push_back(int'(x_out));
            by.push_back(int'(y_out));
            bm.push_back(int'(mask_out));
            bc.push_back(cyc);
        end
        if (new_frame_out) begin
            nf_cnt <= nf_cnt + 1;
            nf_cyc <= cyc;
        end
    end

    bit frame [H][W];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int in_sq(input int x, input int y);
        return ((x >= 40 && x < 48 && y >= 40 && y < 48) ||
                (x >= 200 && x < 208 && y >= 100 && y < 108)) ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_idle();
        pixel_valid_in = 1'b0;
        frame_done_in  = 1'b0;
        km_done_in     = 1'b0;
        mask_in        = 1'($urandom);
        pixel_x_in     = 9'($urandom);
        pixel_y_in     = 8'($urandom);
    endtask

    task automatic clear_beats();
        bx.delete(); by.delete(); bm.delete(); bc.delete();
    endtask

    task automatic pulse_frame_done(output int at);
        drive_idle();
        frame_done_in = 1'b1;
        at = cyc;
        step();
        drive_idle();
    endtask

    task automatic pulse_km_done(output int at);
        drive_idle();
        km_done_in = 1'b1;
        at = cyc;
        step();
        drive_idle();
    endtask

    task automatic sync_frame();
        int d;
        repeat (4) begin
            drive_idle();
            pixel_valid_in = 1'b1;
            pixel_x_in = 9'($urandom_range(0, W - 1));
            pixel_y_in = 8'($urandom_range(0, H - 1));
            mask_in = 1'b1;
            step();
        end
        pulse_frame_done(d);
    endtask

    // kind: 0 random, 1 single pixel, 2 corners + out-of-range ones, 3 no pixels
    task automatic capture_frame(input int kind, output int fd_at);
        int sx, sy;
        sx = $urandom_range(0, W - 1);
        sy = $urandom_range(0, H - 1);
        if (kind == 2) begin
            drive_idle(); pixel_valid_in = 1'b1; mask_in = 1'b1;
            pixel_x_in = 9'(W); pixel_y_in = 8'd3; step();
            drive_idle(); pixel_valid_in = 1'b1; mask_in = 1'b1;
            pixel_x_in = 9'd5; pixel_y_in = 8'(H); step();
        end
        if (kind != 3) begin
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    case (kind)
                        0:       frame[y][x] = 1'($urandom);
                        1:       frame[y][x] = (x == sx && y == sy);
                        default: frame[y][x] = (x == 0 && y == 0) || (x == W - 1 && y == H - 1);
                    endcase
                    if ($urandom_range(0, 7) == 0) begin
                        drive_idle(); mask_in = 1'b1; step();
                    end
                    if ($urandom_range(0, 15) == 0) begin
                        drive_idle(); pixel_valid_in = 1'b1; mask_in = 1'b1;
                        if ($urandom_range(0, 1) == 1) begin
                            pixel_x_in = 9'($urandom_range(W, 511));
                            pixel_y_in = 8'($urandom_range(0, H - 1));
                        end else begin
                            pixel_x_in = 9'($urandom_range(0, W - 1));
                            pixel_y_in = 8'($urandom_range(H, 255));
                        end
                        step();
                    end
                    drive_idle();
                    pixel_valid_in = 1'b1;
                    pixel_x_in = 9'(x);
                    pixel_y_in = 8'(y);
                    mask_in = frame[y][x];
                    step();
                end
            end
        end
        pulse_frame_done(fd_at);
    endtask

    // start = cycle in which the input that launches STREAM was driven.
    task automatic check_stream(input string tag, input int start, input bit pattern,
                                input bit coin, input bit drops);
        int nf0, guard, errs, ones, exp_ones, flush_ones, ex, ey, em;
        nf0 = nf_cnt; guard = 0; errs = 0; ones = 0; exp_ones = 0; flush_ones = 0;
        while (nf_cnt == nf0 && guard < N + 20) begin
            drive_idle();
            if (coin && cyc == start + 2 + N) km_done_in = 1'b1;
            if (drops && (cyc == start + 50 || cyc == start + 120)) frame_done_in = 1'b1;
            step();
            guard++;
        end
        check_val({tag, "_nf_seen"}, int'(nf_cnt != nf0), 1);
        drive_idle();
        step();
        step();
        check_val({tag, "_nf_width"}, nf_cnt - nf0, 1);
        check_val({tag, "_nf_cyc"}, nf_cyc, start + 2 + N);
        check_val({tag, "_busy_after"}, int'(busy_out), 0);
        check_val({tag, "_beats"}, bx.size(), N);
        for (int i = 0; i < N && i < bx.size(); i++) begin
            ex = i % (W + 1);
            ey = i / (W + 1);
            em = (ex < W) ? (pattern ? in_sq(ex, ey) : int'(frame[ey][ex])) : 0;
            if (bx[i] != ex || by[i] != ey || bm[i] != em || bc[i] != start + 2 + i) errs++;
            exp_ones += em;
            ones += bm[i];
            if (bx[i] == W) flush_ones += bm[i];
        end
        check_val({tag, "_raster_errs"}, errs, 0);
        check_val({tag, "_ones"}, ones, exp_ones);
        check_val({tag, "_flush_ones"}, flush_ones, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_x"}, int'(x_out), 511);
        check_val({tag, "_y"}, int'(y_out), 255);
        check_val({tag, "_mask"}, int'(mask_out), 0);
        check_val({tag, "_busy"}, int'(busy_out), 0);
        check_val({tag, "_dropped"}, int'(frames_dropped_out), 0);
    endtask

    initial begin
        int fd, kc, d, nf0;
        rst_in = 1'b0;
        drive_idle();
`ifdef KM_STREAMER_TEST_PATTERN_EN
        test_mode_in = 1'b0;
`endif
        repeat (3) step();
        check_reset_outputs("reset");
        rst_in = 1'b1;
        step();
        step();
        check_val("idle_busy", int'(busy_out), 0);
        sync_frame();
        check_val("capture_busy", int'(busy_out), 1);

`ifdef KM_STREAMER_TEST_PATTERN_EN
        test_mode_in = 1'b1;
        clear_beats();
        capture_frame(3, fd);
        check_stream("pattern", fd, 1'b1, 1'b0, 1'b0);
`else
        // Single pixel; km_ready is set out of reset so the stream starts at once.
        clear_beats();
        capture_frame(1, fd);
        check_stream("single", fd, 1'b0, 1'b0, 1'b0);

        // Corners and out-of-range pixels; km_ready was cleared so the frame waits.
        sync_frame();
        clear_beats();
        capture_frame(2, fd);
        repeat (30) begin drive_idle(); step(); end
        check_val("wait_no_beats", bx.size(), 0);
        check_val("wait_busy", int'(busy_out), 1);
        repeat (3) begin pulse_frame_done(d); step(); end
        check_val("dropped_3", int'(frames_dropped_out), 3);
        pulse_km_done(kc);
        check_stream("boundary", kc, 1'b0, 1'b0, 1'b0);
        check_val("dropped_still_3", int'(frames_dropped_out), 3);

        // Random frame; drops during the stream and km_done on the new_frame_out cycle.
        sync_frame();
        clear_beats();
        capture_frame(0, fd);
        pulse_km_done(kc);
        check_stream("random_c", kc, 1'b0, 1'b1, 1'b1);
        check_val("dropped_5", int'(frames_dropped_out), 5);

        // km_ready survived the coincidence, so this capture streams without waiting.
        sync_frame();
        clear_beats();
        capture_frame(0, fd);
        check_stream("random_d", fd, 1'b0, 1'b0, 1'b0);

        // Saturation, then an asynchronous reset in the middle of a stream.
        sync_frame();
        clear_beats();
        capture_frame(0, fd);
        repeat (260) begin pulse_frame_done(d); step(); end
        check_val("dropped_sat", int'(frames_dropped_out), 255);
        pulse_km_done(kc);
        repeat (2 * W) begin drive_idle(); step(); end
        check_val("partial_beats", bx.size(), 2 * W - 1);
        #2;
        rst_in = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) step();
        rst_in = 1'b1;
        clear_beats();
        nf0 = nf_cnt;
        repeat (N + 10) begin drive_idle(); step(); end
        check_val("no_nf_after_reset", nf_cnt - nf0, 0);
        check_val("no_beats_after_reset", bx.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
